// File: rtl/period_capture.sv
// Input capture: measures active time and period of sig_i in clock cycles.
// Define PERIOD_CAPTURE_SYNC_EN to add a two-flop synchronizer on the input.
module period_capture #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  pol_i,
    input  logic                  sig_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] high_o,
    output logic [DATA_WIDTH-1:0] period_o,
    output logic                  ovf_o,
    output logic                  lost_o,
    output logic                  busy_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARM      = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;
    localparam logic [1:0] ST_INACTIVE = 2'd3;

    localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Handshake: a result is transferred on any cycle where valid_o and ready_i
    // are both high; while valid_o=1 and ready_i=0 the result fields hold.

    logic s_raw;
    logic s;
    logic s_q;
    logic rise;
    logic fall;

    assign s_raw = sig_i ^ pol_i;

`ifdef PERIOD_CAPTURE_SYNC_EN
    logic sync_a;
    logic sync_b;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= s_raw;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b;
`else
    assign s = s_raw;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q <= 1'b0;
        end else begin
            s_q <= s;
        end
    end

    assign rise = s & ~s_q;
    assign fall = ~s & s_q;

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic [DATA_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] cnt_n;
    logic                  sat;
    logic                  sat_n;
    logic [DATA_WIDTH-1:0] high_r;
    logic [DATA_WIDTH-1:0] high_n;
    logic                  cap;

    always_comb begin
        state_n = state;
        cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        sat_n   = sat | (cnt == CNT_MAX);
        high_n  = high_r;
        cap     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n   = '0;
                sat_n   = 1'b0;
                state_n = ST_ARM;
            end
            ST_ARM: begin
                // Any partial period before the first rise is discarded.
                cnt_n = '0;
                sat_n = 1'b0;
                if (rise) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = CNT_ONE;
                end
            end
            ST_ACTIVE: begin
                if (fall) begin
                    high_n  = cnt;
                    state_n = ST_INACTIVE;
                end
            end
            ST_INACTIVE: begin
                if (rise) begin
                    cap     = 1'b1;
                    state_n = ST_ACTIVE;
                    cnt_n   = CNT_ONE;
                    sat_n   = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                sat_n   = 1'b0;
            end
        endcase
        if (!en_i) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            sat_n   = 1'b0;
            cap     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sat      <= 1'b0;
            high_r   <= '0;
            valid_o  <= 1'b0;
            high_o   <= '0;
            period_o <= '0;
            ovf_o    <= 1'b0;
            lost_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else if (clr_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sat      <= 1'b0;
            high_r   <= '0;
            valid_o  <= 1'b0;
            high_o   <= '0;
            period_o <= '0;
            ovf_o    <= 1'b0;
            lost_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sat    <= sat_n;
            high_r <= high_n;
            busy_o <= (state_n != ST_IDLE);
            if (cap) begin
                // A full register that is not being drained keeps its result.
                if (!valid_o || ready_i) begin
                    valid_o  <= 1'b1;
                    high_o   <= high_r;
                    period_o <= cnt;
                    ovf_o    <= sat;
                end else begin
                    lost_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
